ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Execute-stage iterative multiply/divide unit that consumes operands and the decoded operation arriving from the ID/EX pipeline register and owns the architectural HI/LO registers. It accepts one MULT/MULTU/DIV/DIVU per start pulse and computes over multiple cycles while the main pipeline keeps flowing. It raises `busy` so the hazard unit can stall MFHI/MFLO/MTHI/MTLO until the result has landed.

## Interface
- `XLEN`, 32: operand width; the iteration count equals `XLEN`.
- `clk`  input  1  pipeline clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset (asserted at 0).
- `start`  input  1  issue strobe from EX when a mul/div op is in EX and the stage is not flushed.
- `op`  input  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- `a`, `b`  input  XLEN  forwarded rs/rt values (multiplicand/dividend, multiplier/divisor).
- `flush`  input  1  abort the in-flight operation (exception/halt).
- `wr_hi`, `wr_lo`  input  1  MTHI/MTLO write strobes.
- `wdata`  input  XLEN  MTHI/MTLO data.
- `busy`  output  1  operation in flight (`state != IDLE`).
- `done`  output  1  one-cycle pulse: HI/LO were updated by an op on the previous edge.
- `hi`, `lo`  output  XLEN  architectural HI/LO (registered).

## Operation
- States: IDLE, CALC, FIX.
- IDLE + `start`: latch op. For signed ops, latch |a| and |b| plus sign flags sa/sb. Clear the 64-bit accumulator and the 5-bit counter, then go to CALC.
- CALC multiply: radix-2 shift-add, one multiplier bit per cycle, 64-bit product.
- CALC divide: restoring division, one quotient bit per cycle, producing a 32-bit quotient and remainder.
- CALC lasts exactly `XLEN` cycles; leave for FIX when the counter equals `XLEN-1` (no wrap past it).
- FIX, signed multiply: negate the 64-bit product if sa^sb.
- FIX, signed divide: negate the quotient if sa^sb; negate the remainder if sa.
- FIX writes HI/LO: product {hi,lo}; for divide, lo=quotient and hi=remainder. Then go to IDLE with `done`=1.
- Divide by zero (b==0, any divide op): lo=0xFFFFFFFF, hi=a (raw, unsigned view); the op still takes the full latency.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no trap.
- `start` while busy: ignored.
- `flush` in CALC or FIX: return to IDLE next edge; HI/LO are untouched and `done` stays 0. `flush` in IDLE has no effect; `flush` together with `start` in IDLE means the start is dropped.
- `wr_hi`/`wr_lo`: applied only in IDLE and ignored while busy (the hazard unit guarantees they are stalled).
- `wr_hi`/`wr_lo` with `start` in the same IDLE cycle: the write is applied, and the later op result overwrites it.
- Reset: state=IDLE; hi, lo, accumulator and counter = 0; busy=0, done=0.

## Timing
- `start` sampled at edge T0 → `busy` high from T0 to T33, so it is high for 33 cycles.
- HI/LO are valid after edge T33, and `done` is high for the cycle following T33.
- Back-to-back: a `start` in the cycle `done` is high is accepted, with no bubble.
- `hi`/`lo` change only at edges: on FIX, on accepted MTHI/MTLO, or on reset.
- Reset mid-operation: outputs go to their reset values immediately (asynchronous), and the operation is lost.

## Configuration
- `MULDIV_FAST_MUL_EN` defined: multiply ops go IDLE→FIX, using a single-cycle 64-bit `*` product computed on magnitudes at `start`. `busy` is high for 2 cycles and `done` follows the T2 edge. Divide is unchanged.
- Undefined: all ops are iterative as above, so the block contains no hardware multiplier.

## Structure
- Shared package `muldiv_pkg`: op encoding constants (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU), state enum, and `MULDIV_ITERS` = 32.
- One sub-module, `muldiv_sign_adj`: combinational magnitude/negate helper used at issue (abs) and in FIX (conditional 32/64-bit negate).
- The FSM, counter, shift datapath and HI/LO registers live in the top block.

## Test plan
- MULT a=7, b=0xFFFFFFFD (-3) → after T33: hi=0xFFFFFFFF, lo=0xFFFFFFEB; done pulses once; busy is high for 33 cycles.
- DIVU 100/7 → lo=14, hi=2. DIV 0xFFFFFFF9 (-7)/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 5/0 → lo=0xFFFFFFFF, hi=5 at the normal latency. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- MULTU 0xFFFFFFFF×2: pulse `start` again at cycle 5 (ignored), then `flush` at cycle 10 → busy drops next cycle, hi/lo keep their prior values, no done.
- MTHI 0x1234 in IDLE → hi=0x1234 next edge. MTLO during busy → lo unchanged. Back-to-back start on the done cycle is accepted.
- Reset driven low at cycle 5 of a DIV → hi=lo=0 and busy=0 immediately. With `MULDIV_FAST_MUL_EN` defined, MULT 7×-3 → result after 2 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// operation encoding, FSM states and iteration count.
package muldiv_pkg;

  localparam int MULDIV_ITERS = 32;

  localparam logic [1:0] OP_MULT  = 2'd0;
  localparam logic [1:0] OP_MULTU = 2'd1;
  localparam logic [1:0] OP_DIV   = 2'd2;
  localparam logic [1:0] OP_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // MULT and DIV are the signed flavours (op[0] == 0).
  function automatic logic op_is_signed(input logic [1:0] o);
    return ~o[0];
  endfunction

endpackage

// File: rtl/muldiv_sign_adj.sv
// Conditional two's-complement negate; used to take magnitudes at issue
// and to restore result signs in FIX. Purely combinational.
module muldiv_sign_adj #(
  parameter int W = 32
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  assign dout = neg ? -din : din;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; 33-cycle busy window per op.
// Optional MULDIV_FAST_MUL_EN: multiplies use a single-cycle product (2-cycle busy).
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = MULDIV_ITERS
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  input  logic            wr_hi,
  input  logic            wr_lo,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int            CW   = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  state_t              state;
  logic [1:0]          op_q;
  logic                sa;
  logic                sb;
  logic                dz;
  logic [XLEN-1:0]     ma;
  logic [XLEN-1:0]     mb;
  logic [2*XLEN-1:0]   acc;
  logic [CW-1:0]       cnt;

`ifdef MULDIV_FAST_MUL_EN
  logic                fix_hold;
  logic [2*XLEN-1:0]   fast_prod;
`endif

  logic                is_signed_in;
  logic [XLEN-1:0]     a_abs;
  logic [XLEN-1:0]     b_abs;

  logic [XLEN-1:0]     mul_addend;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next;

  logic [XLEN:0]       rem_shift;
  logic                div_fits;
  logic [XLEN-1:0]     div_diff;
  logic [XLEN-1:0]     rem_next;
  logic [2*XLEN-1:0]   div_next;

  logic                fix_neg;
  logic                rem_neg;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quo_fix;
  logic [XLEN-1:0]     rem_fix;
  logic [XLEN-1:0]     res_hi;
  logic [XLEN-1:0]     res_lo;

  assign is_signed_in = op_is_signed(op);

  muldiv_sign_adj #(.W(XLEN)) u_abs_a (
    .din  (a),
    .neg  (is_signed_in & a[XLEN-1]),
    .dout (a_abs)
  );

  muldiv_sign_adj #(.W(XLEN)) u_abs_b (
    .din  (b),
    .neg  (is_signed_in & b[XLEN-1]),
    .dout (b_abs)
  );

`ifdef MULDIV_FAST_MUL_EN
  assign fast_prod = {{XLEN{1'b0}}, a_abs} * {{XLEN{1'b0}}, b_abs};
`endif

  // Multiply: acc[2X-1:X] accumulates, the whole word shifts right each step.
  // Divide: acc[2X-1:X] is the partial remainder, acc[X-1:0] collects quotient
  // bits; the dividend magnitude feeds in MSB-first from ma.
  always_comb begin
    mul_addend = mb[0] ? ma : '0;
    mul_sum    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
    mul_next   = {mul_sum, acc[XLEN-1:1]};

    rem_shift  = {acc[2*XLEN-1:XLEN], ma[XLEN-1]};
    div_fits   = rem_shift >= {1'b0, mb};
    div_diff   = rem_shift[XLEN-1:0] - mb;
    rem_next   = div_fits ? div_diff : rem_shift[XLEN-1:0];
    div_next   = {rem_next, acc[XLEN-2:0], div_fits};
  end

  assign fix_neg = op_is_signed(op_q) & (sa ^ sb);
  assign rem_neg = op_is_signed(op_q) & sa;

  muldiv_sign_adj #(.W(2*XLEN)) u_fix_prod (
    .din  (acc),
    .neg  (fix_neg),
    .dout (prod_fix)
  );

  muldiv_sign_adj #(.W(XLEN)) u_fix_quo (
    .din  (acc[XLEN-1:0]),
    .neg  (fix_neg),
    .dout (quo_fix)
  );

  muldiv_sign_adj #(.W(XLEN)) u_fix_rem (
    .din  (acc[2*XLEN-1:XLEN]),
    .neg  (rem_neg),
    .dout (rem_fix)
  );

  // Divide by zero: the restoring loop already leaves |a| as remainder, and
  // the remainder sign fix turns that back into raw a; only lo needs forcing.
  always_comb begin
    if (op_q[1]) begin
      res_hi = rem_fix;
      res_lo = dz ? '1 : quo_fix;
    end else begin
      res_hi = prod_fix[2*XLEN-1:XLEN];
      res_lo = prod_fix[XLEN-1:0];
    end
  end

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      op_q     <= OP_MULT;
      sa       <= 1'b0;
      sb       <= 1'b0;
      dz       <= 1'b0;
      ma       <= '0;
      mb       <= '0;
      acc      <= '0;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
      fix_hold <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wr_hi) hi <= wdata;
          if (wr_lo) lo <= wdata;
          if (start && !flush) begin
            op_q <= op;
            sa   <= is_signed_in & a[XLEN-1];
            sb   <= is_signed_in & b[XLEN-1];
            dz   <= op[1] & (b == '0);
            ma   <= a_abs;
            mb   <= b_abs;
            cnt  <= '0;
`ifdef MULDIV_FAST_MUL_EN
            if (!op[1]) begin
              acc      <= fast_prod;
              fix_hold <= 1'b1;
              state    <= ST_FIX;
            end else begin
              acc   <= '0;
              state <= ST_CALC;
            end
`else
            acc   <= '0;
            state <= ST_CALC;
`endif
          end
        end

        ST_CALC: begin
          if (flush) begin
            state <= ST_IDLE;
          end else begin
            if (op_q[1]) begin
              acc <= div_next;
              ma  <= {ma[XLEN-2:0], 1'b0};
            end else begin
              acc <= mul_next;
              mb  <= {1'b0, mb[XLEN-1:1]};
            end
            if (cnt == LAST) begin
              state <= ST_FIX;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        ST_FIX: begin
          if (flush) begin
            state <= ST_IDLE;
`ifdef MULDIV_FAST_MUL_EN
          end else if (fix_hold) begin
            fix_hold <= 1'b0;
`endif
          end else begin
            hi    <= res_hi;
            lo    <= res_lo;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vectors, random ops against
// a 64-bit arithmetic reference, flush/ignore/MTHI/MTLO/back-to-back/reset cases.
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
  localparam logic [1:0] FLUSH_OP = OP_DIVU;
`else
  localparam int MUL_LAT = 33;
  localparam logic [1:0] FLUSH_OP = OP_MULTU;
`endif
  localparam int DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        reset, start, flush, wr_hi, wr_lo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .wr_hi (wr_hi),
    .wr_lo (wr_lo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  // Reference result {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy;
    longint unsigned ux, uy;
    logic [63:0]     r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'b0, x};
    uy = {32'b0, y};
    r  = '0;
    case (o)
      OP_MULT:  r = sx * sy;
      OP_MULTU: r = ux * uy;
      OP_DIV: begin
        if (y == 32'd0) r = {x, 32'hFFFFFFFF};
        else begin
          r[31:0]  = 32'(sx / sy);
          r[63:32] = 32'(sx % sy);
        end
      end
      default: begin
        if (y == 32'd0) r = {x, 32'hFFFFFFFF};
        else begin
          r[31:0]  = 32'(ux / uy);
          r[63:32] = 32'(ux % uy);
        end
      end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  // Called on a falling edge; returns on the falling edge after the start edge.
  task automatic drive_start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts busy cycles until done is seen (bounded); stops on the done cycle.
  task automatic wait_done(output int bcyc, output int dcnt);
    bcyc = 0;
    dcnt = 0;
    for (int i = 0; i < 40 && dcnt == 0; i++) begin
      if (busy) bcyc++;
      if (done) dcnt++;
      else @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = 2'd0; a = '0; b = '0; wdata = '0;
    repeat (2) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi: got %h want 0", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo: got %h want 0", lo); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [1:0]  t_op [8] = '{OP_MULT, OP_DIVU, OP_DIV, OP_DIV, OP_DIV, OP_DIVU, OP_MULTU, OP_DIV};
    logic [31:0] t_a  [8] = '{32'd7, 32'd100, 32'hFFFFFFF9, 32'd5, 32'h80000000, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFF8};
    logic [31:0] t_b  [8] = '{32'hFFFFFFFD, 32'd7, 32'd2, 32'd0, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF, 32'd0};
    logic [31:0] e_hi [8] = '{32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'd5, 32'd0, 32'h12345678, 32'hFFFFFFFE, 32'hFFFFFFF8};
    logic [31:0] e_lo [8] = '{32'hFFFFFFEB, 32'd14, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF};
    int bc, dc, lat;
    for (int i = 0; i < 8; i++) begin
      lat = t_op[i][1] ? DIV_LAT : MUL_LAT;
      drive_start(t_op[i], t_a[i], t_b[i]);
      wait_done(bc, dc);
      total++; if (dc !== 1) begin bad++; $display("FAIL dir%0d_done: got %0d want 1", i, dc); end
      total++; if (bc !== lat) begin bad++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, bc, lat); end
      total++; if (hi !== e_hi[i] || lo !== e_lo[i])
        begin bad++; $display("FAIL dir%0d_result: got %h_%h want %h_%h", i, hi, lo, e_hi[i], e_lo[i]); end
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL dir%0d_done_pulse: got %b want 0", i, done); end
    end
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] x, y;
    logic [63:0] exp;
    int bc, dc, lat;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      x = pick();
      y = pick();
      exp = ref_model(o, x, y);
      lat = o[1] ? DIV_LAT : MUL_LAT;
      drive_start(o, x, y);
      wait_done(bc, dc);
      total++; if (dc !== 1 || bc !== lat) begin bad++; $display("FAIL rnd%0d_timing: got busy=%0d done=%0d want busy=%0d done=1", i, bc, dc, lat); end
      total++; if ({hi, lo} !== exp)
        begin bad++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h: got %h want %h", i, o, x, y, {hi, lo}, exp); end
      @(negedge clk);
    end
  endtask

  task automatic test_start_ignored();
    int bc, dc;
    drive_start(OP_DIVU, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    start = 1'b1; op = OP_MULTU; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(bc, dc);
    total++; if (dc !== 1 || bc !== DIV_LAT - 4) begin bad++; $display("FAIL ignore_timing: got busy=%0d done=%0d want busy=%0d done=1", bc, dc, DIV_LAT - 4); end
    total++; if (hi !== 32'd2 || lo !== 32'd14) begin bad++; $display("FAIL ignore_result: got %h_%h want 00000002_0000000e", hi, lo); end
    @(negedge clk);
  endtask

  task automatic test_flush();
    int seen;
    wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hCAFE0001;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
    drive_start(FLUSH_OP, 32'hFFFFFFFF, 32'd2);
    repeat (3) @(negedge clk);
    start = 1'b1; op = OP_DIV; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL flush_pre_busy: got %b want 1", busy); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", busy); end
    total++; if (hi !== 32'hCAFE0001 || lo !== 32'hCAFE0001) begin bad++; $display("FAIL flush_hilo: got %h_%h want cafe0001_cafe0001", hi, lo); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) seen++;
      @(negedge clk);
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL flush_quiet: got %0d active cycles want 0", seen); end
    total++; if (hi !== 32'hCAFE0001 || lo !== 32'hCAFE0001) begin bad++; $display("FAIL flush_hilo_late: got %h_%h want cafe0001_cafe0001", hi, lo); end
  endtask

  task automatic test_mthi_mtlo();
    int bc, dc;
    wr_hi = 1'b1; wdata = 32'h1234;
    @(negedge clk);
    wr_hi = 1'b0;
    total++; if (hi !== 32'h1234) begin bad++; $display("FAIL mthi: got %h want 00001234", hi); end
    wr_lo = 1'b1; wdata = 32'h5678;
    @(negedge clk);
    wr_lo = 1'b0;
    total++; if (lo !== 32'h5678 || hi !== 32'h1234) begin bad++; $display("FAIL mtlo: got %h_%h want 00001234_00005678", hi, lo); end
    drive_start(OP_DIVU, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    wr_lo = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge clk);
    wr_lo = 1'b0;
    total++; if (lo !== 32'h5678) begin bad++; $display("FAIL mtlo_busy: got %h want 00005678", lo); end
    wait_done(bc, dc);
    total++; if (dc !== 1 || hi !== 32'd2 || lo !== 32'd14) begin bad++; $display("FAIL mtlo_busy_result: got %h_%h done=%0d want 00000002_0000000e done=1", hi, lo, dc); end
    @(negedge clk);
  endtask

  task automatic test_wr_with_start();
    int bc, dc;
    start = 1'b1; op = OP_DIVU; a = 32'd9; b = 32'd4; wr_hi = 1'b1; wdata = 32'd77;
    @(negedge clk);
    start = 1'b0; wr_hi = 1'b0;
    total++; if (hi !== 32'd77 || busy !== 1'b1) begin bad++; $display("FAIL wr_start_apply: got hi=%h busy=%b want hi=0000004d busy=1", hi, busy); end
    wait_done(bc, dc);
    total++; if (dc !== 1 || hi !== 32'd1 || lo !== 32'd2) begin bad++; $display("FAIL wr_start_result: got %h_%h done=%0d want 00000001_00000002 done=1", hi, lo, dc); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int bc, dc;
    logic [63:0] exp;
    drive_start(OP_MULTU, 32'd3, 32'd5);
    wait_done(bc, dc);
    total++; if (dc !== 1 || {hi, lo} !== 64'd15) begin bad++; $display("FAIL b2b_first: got %h_%h done=%0d want 00000000_0000000f done=1", hi, lo, dc); end
    exp = ref_model(OP_DIV, 32'hFFFFFF9C, 32'd7);
    drive_start(OP_DIV, 32'hFFFFFF9C, 32'd7);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
    wait_done(bc, dc);
    total++; if (dc !== 1 || bc !== DIV_LAT) begin bad++; $display("FAIL b2b_timing: got busy=%0d done=%0d want busy=%0d done=1", bc, dc, DIV_LAT); end
    total++; if ({hi, lo} !== exp) begin bad++; $display("FAIL b2b_result: got %h want %h", {hi, lo}, exp); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    drive_start(OP_DIV, 32'd1000, 32'd3);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_mid_ctrl: got busy=%b done=%b want 0 0", busy, done); end
    total++; if (hi !== 32'h0 || lo !== 32'h0) begin bad++; $display("FAIL rst_mid_hilo: got %h_%h want 00000000_00000000", hi, lo); end
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0 || lo !== 32'h0) begin bad++; $display("FAIL rst_mid_after: got busy=%b lo=%h want 0 00000000", busy, lo); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_flush();
    test_mthi_mtlo();
    test_wr_with_start();
    test_back_to_back();
    test_reset_mid_op();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
